// File: rtl/riscv_dmem_arbiter.sv
// ---------------------------------------------------------------------------
// riscv_dmem_arbiter
// Shares the single data-cache request port between the LSU (port 0) and a
// secondary master such as debug or DMA (port 1). Responses come back in
// order, so a small FIFO of port IDs steers each ack to the right requester.
//
// Ports:
//   clk_i, rst_ni              clock, asynchronous active-low reset
//   req{0,1}_*_i               request bus from each requester
//   req{0,1}_accept_o          request taken by the cache this cycle
//   req{0,1}_ack/error/data_rd/resp_tag_o  routed response
//   mem_*_o                    muxed request bus to the cache
//   mem_accept/ack/error/data_rd/resp_tag_i  cache handshake and response
//   busy_o                     at least one request outstanding
//
// Build option: RISCV_DMEM_ARB_FIXED_PRIO_EN gives port 0 fixed priority on
// an idle conflict instead of round-robin.
//
// state | meaning
// IDLE  | no frozen grant, winner chosen combinationally
// LOCK0 | port 0 presented but not yet accepted, grant held
// LOCK1 | port 1 presented but not yet accepted, grant held
// ---------------------------------------------------------------------------
module riscv_dmem_arbiter #(
  parameter int MAX_OUTSTANDING = 4,
  parameter int CNT_W           = 3
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic [31:0] req0_addr_i,
  input  logic [31:0] req0_data_wr_i,
  input  logic        req0_rd_i,
  input  logic [3:0]  req0_wr_i,
  input  logic        req0_cacheable_i,
  input  logic [10:0] req0_req_tag_i,
  input  logic        req0_invalidate_i,
  input  logic        req0_flush_i,
  output logic        req0_accept_o,
  output logic        req0_ack_o,
  output logic        req0_error_o,
  output logic [31:0] req0_data_rd_o,
  output logic [10:0] req0_resp_tag_o,
  input  logic [31:0] req1_addr_i,
  input  logic [31:0] req1_data_wr_i,
  input  logic        req1_rd_i,
  input  logic [3:0]  req1_wr_i,
  input  logic        req1_cacheable_i,
  input  logic [10:0] req1_req_tag_i,
  input  logic        req1_invalidate_i,
  input  logic        req1_flush_i,
  output logic        req1_accept_o,
  output logic        req1_ack_o,
  output logic        req1_error_o,
  output logic [31:0] req1_data_rd_o,
  output logic [10:0] req1_resp_tag_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_data_wr_o,
  output logic        mem_rd_o,
  output logic [3:0]  mem_wr_o,
  output logic        mem_cacheable_o,
  output logic [10:0] mem_req_tag_o,
  output logic        mem_invalidate_o,
  output logic        mem_flush_o,
  input  logic        mem_accept_i,
  input  logic        mem_ack_i,
  input  logic        mem_error_i,
  input  logic [31:0] mem_data_rd_i,
  input  logic [10:0] mem_resp_tag_i,
  output logic        busy_o
);

  localparam int PTR_W = $clog2(MAX_OUTSTANDING);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_LOCK0 = 2'd1;
  localparam logic [1:0] ST_LOCK1 = 2'd2;

  logic             valid0, valid1;
  logic [1:0]       state_q, state_d;
  logic             last_q;
  logic             gnt_any, gnt_port;
  logic             push, pop, fifo_full, fifo_empty, head_id;
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             id_q [MAX_OUTSTANDING];

  assign valid0 = req0_rd_i | (|req0_wr_i) | req0_invalidate_i | req0_flush_i;
  assign valid1 = req1_rd_i | (|req1_wr_i) | req1_invalidate_i | req1_flush_i;

  always_comb begin
    gnt_any  = 1'b0;
    gnt_port = 1'b0;
    case (state_q)
      ST_LOCK0: gnt_any = valid0;
      ST_LOCK1: begin
        gnt_any  = valid1;
        gnt_port = 1'b1;
      end
      default: begin
        if (valid0 && valid1) begin
          gnt_any = 1'b1;
`ifdef RISCV_DMEM_ARB_FIXED_PRIO_EN
          gnt_port = 1'b0;
`else
          // Whoever was not accepted last goes first.
          gnt_port = ~last_q;
`endif
        end else if (valid0) begin
          gnt_any = 1'b1;
        end else if (valid1) begin
          gnt_any  = 1'b1;
          gnt_port = 1'b1;
        end
      end
    endcase
  end

  assign fifo_full  = (count_q == CNT_W'(MAX_OUTSTANDING));
  assign fifo_empty = (count_q == '0);
  assign push       = gnt_any & mem_accept_i & ~fifo_full;
  assign pop        = mem_ack_i & ~fifo_empty;
  assign head_id    = id_q[rd_ptr_q];

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (gnt_any && !push) state_d = gnt_port ? ST_LOCK1 : ST_LOCK0;
      default: if (push || !gnt_any) state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= ST_IDLE;
      last_q   <= 1'b1;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      state_q <= state_d;
      if (push) begin
        last_q   <= gnt_port;
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // ID storage needs no reset: entries are only read behind a valid count.
  always_ff @(posedge clk_i) begin
    if (push) id_q[wr_ptr_q] <= gnt_port;
  end

  assign req0_accept_o = push & ~gnt_port;
  assign req1_accept_o = push & gnt_port;

  // Address/data fields follow the grant; only the strobes are gated when
  // the ID FIFO is full so the cache sees no request.
  always_comb begin
    mem_addr_o       = '0;
    mem_data_wr_o    = '0;
    mem_rd_o         = 1'b0;
    mem_wr_o         = '0;
    mem_cacheable_o  = 1'b0;
    mem_req_tag_o    = '0;
    mem_invalidate_o = 1'b0;
    mem_flush_o      = 1'b0;
    if (gnt_any) begin
      if (gnt_port) begin
        mem_addr_o       = req1_addr_i;
        mem_data_wr_o    = req1_data_wr_i;
        mem_rd_o         = req1_rd_i & ~fifo_full;
        mem_wr_o         = req1_wr_i & {4{~fifo_full}};
        mem_cacheable_o  = req1_cacheable_i;
        mem_req_tag_o    = req1_req_tag_i;
        mem_invalidate_o = req1_invalidate_i & ~fifo_full;
        mem_flush_o      = req1_flush_i & ~fifo_full;
      end else begin
        mem_addr_o       = req0_addr_i;
        mem_data_wr_o    = req0_data_wr_i;
        mem_rd_o         = req0_rd_i & ~fifo_full;
        mem_wr_o         = req0_wr_i & {4{~fifo_full}};
        mem_cacheable_o  = req0_cacheable_i;
        mem_req_tag_o    = req0_req_tag_i;
        mem_invalidate_o = req0_invalidate_i & ~fifo_full;
        mem_flush_o      = req0_flush_i & ~fifo_full;
      end
    end
  end

  assign req0_ack_o      = pop & ~head_id;
  assign req1_ack_o      = pop & head_id;
  assign req0_error_o    = req0_ack_o & mem_error_i;
  assign req1_error_o    = req1_ack_o & mem_error_i;
  assign req0_data_rd_o  = req0_ack_o ? mem_data_rd_i : '0;
  assign req1_data_rd_o  = req1_ack_o ? mem_data_rd_i : '0;
  assign req0_resp_tag_o = req0_ack_o ? mem_resp_tag_i : '0;
  assign req1_resp_tag_o = req1_ack_o ? mem_resp_tag_i : '0;

  assign busy_o = ~fifo_empty;

endmodule

// File: tb/tb_riscv_dmem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_riscv_dmem_arbiter
// Directed scenarios followed by random traffic. A queue-based reference
// model predicts grants, accepts, downstream bus and response routing.
// ---------------------------------------------------------------------------
module tb_riscv_dmem_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic [31:0] r0_addr, r0_wdata, r1_addr, r1_wdata;
  logic        r0_rd, r1_rd, r0_cache, r1_cache, r0_inv, r1_inv, r0_flush, r1_flush;
  logic [3:0]  r0_wr, r1_wr;
  logic [10:0] r0_tag, r1_tag;
  logic        acc0, ack0, err0, acc1, ack1, err1;
  logic [31:0] rdata0, rdata1;
  logic [10:0] rtag0, rtag1;
  logic [31:0] m_addr, m_wdata;
  logic        m_rd, m_cache, m_inv, m_flush;
  logic [3:0]  m_wr;
  logic [10:0] m_tag;
  logic        acc_in, ack_in, err_in;
  logic [31:0] rdata_in;
  logic [10:0] rtag_in;
  logic        busy;

  riscv_dmem_arbiter #(.MAX_OUTSTANDING(4), .CNT_W(3)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .req0_addr_i(r0_addr), .req0_data_wr_i(r0_wdata), .req0_rd_i(r0_rd),
    .req0_wr_i(r0_wr), .req0_cacheable_i(r0_cache), .req0_req_tag_i(r0_tag),
    .req0_invalidate_i(r0_inv), .req0_flush_i(r0_flush),
    .req0_accept_o(acc0), .req0_ack_o(ack0), .req0_error_o(err0),
    .req0_data_rd_o(rdata0), .req0_resp_tag_o(rtag0),
    .req1_addr_i(r1_addr), .req1_data_wr_i(r1_wdata), .req1_rd_i(r1_rd),
    .req1_wr_i(r1_wr), .req1_cacheable_i(r1_cache), .req1_req_tag_i(r1_tag),
    .req1_invalidate_i(r1_inv), .req1_flush_i(r1_flush),
    .req1_accept_o(acc1), .req1_ack_o(ack1), .req1_error_o(err1),
    .req1_data_rd_o(rdata1), .req1_resp_tag_o(rtag1),
    .mem_addr_o(m_addr), .mem_data_wr_o(m_wdata), .mem_rd_o(m_rd),
    .mem_wr_o(m_wr), .mem_cacheable_o(m_cache), .mem_req_tag_o(m_tag),
    .mem_invalidate_o(m_inv), .mem_flush_o(m_flush),
    .mem_accept_i(acc_in), .mem_ack_i(ack_in), .mem_error_i(err_in),
    .mem_data_rd_i(rdata_in), .mem_resp_tag_i(rtag_in),
    .busy_o(busy)
  );

  typedef struct {
    bit          v;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        rd;
    logic [3:0]  wr;
    logic        cache;
    logic [10:0] tag;
    logic        inv;
    logic        flush;
  } req_t;

  req_t pend[2];
  int   outq[$];   // port IDs of accepted, unanswered requests, oldest first
  int   held;      // port whose presented request is still waiting, or -1
  int   prefer;    // port that wins the next idle conflict
  int   tests = 0;
  int   fails = 0;

  function automatic req_t empty_req();
    req_t r;
    r.v = 0; r.addr = '0; r.wdata = '0; r.rd = 0; r.wr = '0;
    r.cache = 0; r.tag = '0; r.inv = 0; r.flush = 0;
    return r;
  endfunction

  function automatic req_t rd_req(logic [31:0] a, logic [10:0] t);
    req_t r = empty_req();
    r.v = 1; r.addr = a; r.rd = 1; r.tag = t; r.cache = 1;
    return r;
  endfunction

  function automatic req_t rand_req();
    req_t r = empty_req();
    int   kind = $urandom_range(0, 7);
    r.v     = 1;
    r.addr  = $urandom & 32'hFFFF_FFFC;
    r.wdata = $urandom;
    r.cache = 1'($urandom_range(0, 1));
    r.tag   = 11'($urandom_range(0, 2047));
    if (kind < 4)       r.rd = 1;
    else if (kind < 6)  r.wr = 4'($urandom_range(1, 15));
    else if (kind == 6) r.inv = 1;
    else                r.flush = 1;
    return r;
  endfunction

  function automatic logic [82:0] bus_of(req_t r, bit strobes);
    return {r.addr, r.wdata, r.rd & strobes, r.wr & {4{strobes}}, r.cache,
            r.tag, r.inv & strobes, r.flush & strobes};
  endfunction

  function automatic int winner();
    if (held >= 0) return held;
    if (pend[0].v && pend[1].v) return prefer;
    if (pend[0].v) return 0;
    if (pend[1].v) return 1;
    return -1;
  endfunction

  task automatic check(string tag, logic [82:0] obs, logic [82:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive();
    r0_addr = pend[0].addr; r0_wdata = pend[0].wdata; r0_rd = pend[0].rd;
    r0_wr = pend[0].wr; r0_cache = pend[0].cache; r0_tag = pend[0].tag;
    r0_inv = pend[0].inv; r0_flush = pend[0].flush;
    r1_addr = pend[1].addr; r1_wdata = pend[1].wdata; r1_rd = pend[1].rd;
    r1_wr = pend[1].wr; r1_cache = pend[1].cache; r1_tag = pend[1].tag;
    r1_inv = pend[1].inv; r1_flush = pend[1].flush;
  endtask

  task automatic model_reset();
    outq.delete();
    held   = -1;
    prefer = 0;
    pend[0] = empty_req();
    pend[1] = empty_req();
  endtask

  // One clock: inputs are applied just after a rising edge, outputs are
  // checked mid-cycle, then the model advances on the next rising edge.
  task automatic step();
    int          g, ap;
    bit          full, accepted;
    logic [44:0] e0, e1;
    drive();
    #4;
    g        = winner();
    full     = (outq.size() >= 4);
    accepted = (g >= 0) && acc_in && !full;
    ap       = (ack_in && outq.size() > 0) ? outq[0] : -1;
    e0 = (ap == 0) ? {1'b1, err_in, rdata_in, rtag_in} : '0;
    e1 = (ap == 1) ? {1'b1, err_in, rdata_in, rtag_in} : '0;
    check("accept0", 83'(acc0), 83'(accepted && g == 0));
    check("accept1", 83'(acc1), 83'(accepted && g == 1));
    check("mem_bus", {m_addr, m_wdata, m_rd, m_wr, m_cache, m_tag, m_inv, m_flush},
          (g >= 0) ? bus_of(pend[g], !full) : '0);
    check("resp0", 83'({ack0, err0, rdata0, rtag0}), 83'(e0));
    check("resp1", 83'({ack1, err1, rdata1, rtag1}), 83'(e1));
    check("busy", 83'(busy), 83'(outq.size() != 0));
    @(posedge clk);
    if (rst_n) begin
      if (ap >= 0) void'(outq.pop_front());
      if (accepted) begin
        outq.push_back(g);
`ifdef RISCV_DMEM_ARB_FIXED_PRIO_EN
        prefer = 0;
`else
        prefer = 1 - g;
`endif
        held    = -1;
        pend[g] = empty_req();
      end else if (g >= 0) begin
        held = g;
      end
    end
    #1;
  endtask

  task automatic set_resp(bit a, logic [31:0] d, logic [10:0] t, bit e);
    ack_in = a; rdata_in = d; rtag_in = t; err_in = e;
  endtask

  initial begin
    model_reset();
    rst_n = 1'b0;
    acc_in = 0;
    set_resp(0, '0, '0, 0);
    drive();
    #12;
    repeat (2) step();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Idle after reset
    repeat (2) step();

    // Single LSU load, response two cycles later
    pend[0] = rd_req(32'h0000_1000, 11'h123);
    acc_in  = 1;
    step();
    step();
    set_resp(1, 32'hDEAD_BEEF, 11'h123, 0);
    step();
    set_resp(0, '0, '0, 0);

    // Both ports streaming reads: alternation, then in-order responses
    for (int i = 0; i < 4; i++) begin
      if (!pend[0].v) pend[0] = rd_req(32'h2000 + 32'(i * 4), 11'(i));
      if (!pend[1].v) pend[1] = rd_req(32'h3000 + 32'(i * 4), 11'(16 + i));
      step();
    end
    acc_in = 0;
    for (int i = 0; i < 6 && outq.size() > 0; i++) begin
      set_resp(1, 32'hA000_0000 + 32'(i), 11'(i), 1'(i == 1));
      step();
    end
    set_resp(0, '0, '0, 0);
    pend[0] = empty_req();
    pend[1] = empty_req();
    held    = (held >= 0) ? held : -1;
    step();

    // Port 1 locked while the cache stalls, port 0 joins late
    pend[1] = rd_req(32'h4000, 11'h011);
    acc_in  = 0;
    step();
    pend[0] = rd_req(32'h5000, 11'h022);
    step();
    step();
    acc_in = 1;
    step();
    step();
    acc_in = 0;
    set_resp(1, 32'h1111_1111, 11'h011, 0);
    step();
    set_resp(1, 32'h2222_2222, 11'h022, 0);
    step();
    set_resp(0, '0, '0, 0);

    // Fill the ID FIFO, then free one slot, then push+pop together
    acc_in = 1;
    for (int i = 0; i < 5; i++) begin
      if (!pend[0].v) pend[0] = rd_req(32'h6000 + 32'(i * 4), 11'(32 + i));
      step();
    end
    set_resp(1, 32'h3333_3333, 11'd32, 0);
    step();
    set_resp(0, '0, '0, 0);
    step();
    set_resp(1, 32'h4444_4444, 11'd33, 0);
    step();
    if (!pend[0].v) pend[0] = rd_req(32'h7000, 11'h077);
    step();
    step();
    acc_in = 0;
    pend[0] = empty_req();
    held    = -1;
    for (int i = 0; i < 8 && outq.size() > 0; i++) begin
      set_resp(1, $urandom, 11'($urandom_range(0, 2047)), 0);
      step();
    end
    set_resp(0, '0, '0, 0);

    // Reset with two requests outstanding; late responses are dropped
    acc_in = 1;
    pend[0] = rd_req(32'h8000, 11'h100);
    step();
    pend[1] = rd_req(32'h8004, 11'h101);
    step();
    rst_n = 1'b0;
    model_reset();
    acc_in = 0;
    step();
    rst_n = 1'b1;
    set_resp(1, 32'hBAD0_BAD0, 11'h100, 0);
    step();
    step();
    set_resp(0, '0, '0, 0);
    step();

    // Random traffic
    for (int c = 0; c < 3000; c++) begin
      for (int p = 0; p < 2; p++)
        if (!pend[p].v && $urandom_range(0, 2) == 0) pend[p] = rand_req();
      acc_in = ($urandom_range(0, 3) != 0);
      if (outq.size() > 0)
        set_resp(1'($urandom_range(0, 1)), $urandom, 11'($urandom_range(0, 2047)),
                 1'($urandom_range(0, 1)));
      else
        set_resp(1'($urandom_range(0, 3) == 0), $urandom, 11'($urandom_range(0, 2047)), 0);
      step();
    end

    // Drain
    for (int p = 0; p < 2; p++) if (!pend[p].v) pend[p] = empty_req();
    acc_in = 1;
    for (int i = 0; i < 20 && (pend[0].v || pend[1].v || outq.size() > 0); i++) begin
      set_resp(1'(outq.size() > 0), $urandom, 11'($urandom_range(0, 2047)), 0);
      step();
    end
    set_resp(0, '0, '0, 0);
    step();
    check("drained", 83'(busy), 83'(0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
